// File: rtl/scope_pkg.sv
// Shared definitions for the oscilloscope capture path and the VGA trace renderer.
package scope_pkg;

    localparam int unsigned ScopeDataW = 8;
    localparam int unsigned ScopeDepth = 640;
    localparam int unsigned ScopeAddrW = 10;
    localparam int unsigned ScopeAutoTimeout = 1024;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } scope_state_e;

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module scope_sample_ram
    import scope_pkg::*;
#(
    parameter int unsigned DataW = ScopeDataW,
    parameter int unsigned Depth = ScopeDepth,
    parameter int unsigned AddrW = ScopeAddrW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rdata_q;
    logic             raddr_ok;

    // Extra bit keeps the bound correct when Depth == 2**AddrW.
    assign raddr_ok = {1'b0, raddr_i} < (AddrW + 1)'(Depth);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (raddr_ok) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_capture.sv
// One-shot triggered acquisition into a per-column sample buffer, with optional
// auto-trigger timeout so a flat input still produces a trace.
module scope_capture
    import scope_pkg::*;
#(
    parameter int unsigned DataW       = ScopeDataW,
    parameter int unsigned Depth       = ScopeDepth,
    parameter int unsigned AddrW       = ScopeAddrW,
    parameter int unsigned AutoTimeout = ScopeAutoTimeout
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sample_en_i,
    input  logic [DataW-1:0] sample_i,
    input  logic [DataW-1:0] trig_level_i,
    input  logic             trig_slope_i,
    input  logic             auto_en_i,
    input  logic             arm_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [DataW-1:0] rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             auto_trig_o
);

    localparam int unsigned CntW = $clog2(AutoTimeout);
    localparam logic [CntW-1:0] CntLast = CntW'(AutoTimeout - 1);
    localparam logic [AddrW-1:0] PtrLast = AddrW'(Depth - 1);

    scope_state_e     state_q, state_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  to_cnt_q, to_cnt_d;
    logic [DataW-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             auto_trig_q, auto_trig_d;
    logic             trig_hit;
    logic             force_trig;
    logic             we;
    logic [AddrW-1:0] waddr;

    always_comb begin
        if (trig_slope_i) begin
            trig_hit = (prev_q < trig_level_i) && (sample_i >= trig_level_i);
        end else begin
            trig_hit = (prev_q > trig_level_i) && (sample_i <= trig_level_i);
        end
        force_trig = auto_en_i && (to_cnt_q == CntLast);
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        to_cnt_d     = to_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        auto_trig_d  = auto_trig_q;
        we           = 1'b0;
        waddr        = wr_ptr_q;

        unique case (state_q)
            StIdle, StDone: begin
                // A strobe landing with arm is dropped entirely.
                if (arm_i) begin
                    state_d      = StArmed;
                    wr_ptr_d     = '0;
                    to_cnt_d     = '0;
                    prev_valid_d = 1'b0;
                    auto_trig_d  = 1'b0;
                end
            end
            StArmed: begin
                if (sample_en_i) begin
                    prev_d       = sample_i;
                    prev_valid_d = 1'b1;
                    // The first sample only seeds prev; it neither triggers nor counts.
                    if (prev_valid_q) begin
                        if (trig_hit || force_trig) begin
                            we       = 1'b1;
                            waddr    = '0;
                            wr_ptr_d = AddrW'(1);
                            state_d  = StCapture;
                            if (!trig_hit) begin
                                auto_trig_d = 1'b1;
                            end
                        end else if (auto_en_i && (to_cnt_q != CntLast)) begin
                            to_cnt_d = to_cnt_q + CntW'(1);
                        end
                    end
                end
            end
            StCapture: begin
                if (sample_en_i) begin
                    we = 1'b1;
                    if (wr_ptr_q == PtrLast) begin
                        state_d = StDone;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AddrW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            to_cnt_q     <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            auto_trig_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            to_cnt_q     <= to_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            auto_trig_q  <= auto_trig_d;
        end
    end

    scope_sample_ram #(
        .DataW (DataW),
        .Depth (Depth),
        .AddrW (AddrW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (sample_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

    assign busy_o      = (state_q == StArmed) || (state_q == StCapture);
    assign done_o      = (state_q == StDone);
    assign auto_trig_o = auto_trig_q;

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: stimulus queues expectations, a monitor checks them.
module tb_scope_capture;

    localparam int unsigned DataW = 8;
    localparam int unsigned Depth = 640;
    localparam int unsigned AddrW = 10;
    localparam int unsigned AutoTimeout = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_en = 1'b0;
    logic [DataW-1:0] sample_in = '0;
    logic [DataW-1:0] trig_level = '0;
    logic             trig_slope = 1'b0;
    logic             auto_en = 1'b0;
    logic             arm = 1'b0;
    logic [AddrW-1:0] rd_addr = '0;
    logic [DataW-1:0] rd_data;
    logic             busy, done, auto_trig;

    typedef struct {
        string            name;
        logic [DataW-1:0] exp;
    } rd_exp_t;

    typedef struct {
        string      name;
        logic [2:0] exp;  // {busy, done, auto_trig}
    } st_exp_t;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    logic    rd_req = 1'b0;
    logic    rd_vld = 1'b0;
    int      n_vec = 0;
    int      n_err = 0;

    always #5 clk = ~clk;

    scope_capture #(
        .DataW       (DataW),
        .Depth       (Depth),
        .AddrW       (AddrW),
        .AutoTimeout (AutoTimeout)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sample_en_i  (sample_en),
        .sample_i     (sample_in),
        .trig_level_i (trig_level),
        .trig_slope_i (trig_slope),
        .auto_en_i    (auto_en),
        .arm_i        (arm),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .busy_o       (busy),
        .done_o       (done),
        .auto_trig_o  (auto_trig)
    );

    // Read data is presented one clock after the request.
    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        rd_exp_t e;
        st_exp_t s;
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: read returned %0d with nothing expected", rd_data);
            end else begin
                e = rd_q.pop_front();
                n_vec++;
                if (rd_data !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: rd_data=%0d expected %0d", e.name, rd_data, e.exp);
                end
            end
        end
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            n_vec++;
            if ({busy, done, auto_trig} !== s.exp) begin
                n_err++;
                $display("FAIL %s: busy/done/auto=%b expected %b", s.name,
                         {busy, done, auto_trig}, s.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DataW-1:0] v);
        sample_en = 1'b1;
        sample_in = v;
        tick();
        sample_en = 1'b0;
        tick();
    endtask

    task automatic fill(input int n, input logic [DataW-1:0] v);
        for (int i = 0; i < n; i++) strobe(v);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic exp_st(input string nm, input logic b, input logic d, input logic a);
        st_exp_t t;
        t.name = nm;
        t.exp  = {b, d, a};
        st_q.push_back(t);
        tick();
    endtask

    task automatic rd_chk(input string nm, input logic [AddrW-1:0] a,
                          input logic [DataW-1:0] v);
        rd_exp_t t;
        t.name = nm;
        t.exp  = v;
        rd_q.push_back(t);
        rd_addr = a;
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs.
        tick();
        for (int i = 0; i < 6; i++) begin
            sample_en  = 1'($urandom);
            sample_in  = 8'($urandom);
            trig_level = 8'($urandom);
            trig_slope = 1'($urandom);
            auto_en    = 1'($urandom);
            arm        = 1'($urandom);
            tick();
        end
        exp_st("reset_status", 1'b0, 1'b0, 1'b0);
        rd_chk("reset_rd_data", 10'd5, 8'd0);
        sample_en = 1'b0; arm = 1'b0; auto_en = 1'b0;
        rst_n = 1'b1;
        tick();
        exp_st("idle_status", 1'b0, 1'b0, 1'b0);

        // Rising trigger on a ramp: 130 is the first sample >=128 after one below.
        trig_level = 8'd128; trig_slope = 1'b1;
        do_arm();
        exp_st("rise_armed", 1'b1, 1'b0, 1'b0);
        strobe(8'd100); strobe(8'd110); strobe(8'd120); strobe(8'd130);
        for (int i = 1; i < 639; i++) strobe(8'(130 + 10 * i));
        exp_st("rise_before_last", 1'b1, 1'b0, 1'b0);
        strobe(8'(130 + 10 * 639));
        exp_st("rise_done", 1'b0, 1'b1, 1'b0);
        rd_chk("rise_mem0", 10'd0, 8'd130);
        rd_chk("rise_mem1", 10'd1, 8'd140);
        rd_chk("rise_mem639", 10'd639, 8'd120);
        rd_chk("rise_mem640", 10'd640, 8'd0);

        // Falling trigger; stale prev (130) must not make the first sample (60) fire.
        trig_slope = 1'b0;
        do_arm();
        strobe(8'd60); strobe(8'd200); strobe(8'd50);
        fill(638, 8'd7);
        exp_st("fall_before_last", 1'b1, 1'b0, 1'b0);
        strobe(8'd7);
        exp_st("fall_done", 1'b0, 1'b1, 1'b0);
        rd_chk("fall_mem0", 10'd0, 8'd50);
        rd_chk("fall_mem1", 10'd1, 8'd7);

        // Auto trigger: flat input fires on the 17th strobe.
        trig_slope = 1'b1; auto_en = 1'b1;
        do_arm();
        fill(16, 8'd10);
        exp_st("auto_16", 1'b1, 1'b0, 1'b0);
        strobe(8'd10);
        exp_st("auto_17", 1'b1, 1'b0, 1'b1);
        fill(638, 8'd10);
        exp_st("auto_before_last", 1'b1, 1'b0, 1'b1);
        strobe(8'd10);
        exp_st("auto_done", 1'b0, 1'b1, 1'b1);
        rd_chk("auto_mem0", 10'd0, 8'd10);
        rd_chk("auto_mem320", 10'd320, 8'd10);
        rd_chk("auto_mem639", 10'd639, 8'd10);

        // auto_en=0 holds ARMED and freezes the timeout count.
        auto_en = 1'b0;
        do_arm();
        exp_st("auto_cleared", 1'b1, 1'b0, 1'b0);
        fill(40, 8'd10);
        exp_st("auto_off_hold", 1'b1, 1'b0, 1'b0);
        auto_en = 1'b1;
        fill(15, 8'd10);
        exp_st("auto_resume_15", 1'b1, 1'b0, 1'b0);
        strobe(8'd10);
        exp_st("auto_resume_16", 1'b1, 1'b0, 1'b1);
        fill(639, 8'd11);
        exp_st("auto2_done", 1'b0, 1'b1, 1'b1);
        rd_chk("auto2_mem0", 10'd0, 8'd10);
        rd_chk("auto2_mem639", 10'd639, 8'd11);

        // Arm during CAPTURE is ignored.
        auto_en = 1'b0;
        do_arm();
        strobe(8'd100); strobe(8'd200);
        do_arm();
        exp_st("cap_arm_busy", 1'b1, 1'b0, 1'b0);
        fill(638, 8'd5);
        exp_st("cap_arm_before_last", 1'b1, 1'b0, 1'b0);
        strobe(8'd5);
        exp_st("cap_arm_done", 1'b0, 1'b1, 1'b0);
        rd_chk("cap_arm_mem0", 10'd0, 8'd200);
        rd_chk("cap_arm_mem639", 10'd639, 8'd5);

        // Strobe coincident with arm is neither stored nor compared.
        arm = 1'b1; sample_en = 1'b1; sample_in = 8'd100;
        tick();
        arm = 1'b0; sample_en = 1'b0;
        tick();
        strobe(8'd200); strobe(8'd100); strobe(8'd150);
        fill(638, 8'd6);
        exp_st("coinc_before_last", 1'b1, 1'b0, 1'b0);
        strobe(8'd6);
        exp_st("coinc_done", 1'b0, 1'b1, 1'b0);
        rd_chk("coinc_mem0", 10'd0, 8'd150);
        rd_chk("coinc_mem1", 10'd1, 8'd6);

        // Reset at wr_ptr=300, then a clean re-capture.
        do_arm();
        strobe(8'd100); strobe(8'd200);
        fill(299, 8'd8);
        exp_st("mid_busy", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        exp_st("mid_reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_st("mid_after_reset", 1'b0, 1'b0, 1'b0);
        do_arm();
        strobe(8'd100); strobe(8'd140);
        fill(638, 8'd9);
        exp_st("rearm_before_last", 1'b1, 1'b0, 1'b0);
        strobe(8'd9);
        exp_st("rearm_done", 1'b0, 1'b1, 1'b0);
        rd_chk("rearm_mem0", 10'd0, 8'd140);
        rd_chk("rearm_mem300", 10'd300, 8'd9);
        rd_chk("rearm_mem639", 10'd639, 8'd9);
        for (int a = 640; a < 1024; a++) rd_chk("rd_out_of_range", 10'(a), 8'd0);

        tick(); tick();
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d reads and %0d status checks never compared, expected 0",
                     rd_q.size(), st_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
